// File: rtl/run_ctrl.sv
// Run-control unit: debounces board buttons, arbitrates them against CPU
// exception codes and drives the core clock-enable, cycle counter and halt cause.
module run_ctrl #(
  parameter int CNT_W       = 32,
  parameter int DB_CYCLES   = 16,
  parameter int STEP_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             btn_rst_i,
  input  logic             btn_err_i,
  input  logic             btn_pause_i,
  input  logic             btn_continue_i,
  input  logic             btn_uart_i,
  input  logic             btn_step_i,
  input  logic [3:0]       exc_code_i,
  input  logic             clr_cnt_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [3:0]       mode_o,
  output logic             run_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [1:0]       halt_cause_o,
  output logic             wdog_o
);

  localparam logic [3:0] MODE_ERROR = 4'd2;
  localparam logic [3:0] MODE_PAUSE = 4'd4;
  localparam logic [3:0] MODE_RUN   = 4'd5;
  localparam logic [3:0] MODE_UART  = 4'd6;
  localparam logic [3:0] MODE_STEP  = 4'd7;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_BTN  = 2'd1;
  localparam logic [1:0] CAUSE_EXC  = 2'd2;
  localparam logic [1:0] CAUSE_WDOG = 2'd3;

  localparam int ST_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES + 1) : 1;

  // Button bit order: 0 rst, 1 err, 2 pause, 3 continue, 4 uart, 5 step
  logic [5:0] btnRaw;
  logic [5:0] sync1_q, sync2_q;
  logic [5:0] pulse_q;

  assign btnRaw = {btn_step_i, btn_uart_i, btn_continue_i,
                   btn_pause_i, btn_err_i, btn_rst_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btnRaw;
      sync2_q <= sync1_q;
    end
  end

  generate
    if (DB_CYCLES == 0) begin : g_nodb
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          pulse_q <= '0;
        end else begin
          pulse_q <= sync1_q & ~sync2_q;
        end
      end
    end else begin : g_db
      localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
      localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

      logic [5:0]      level_q;
      logic [DB_W-1:0] dbCnt_q [6];

      // A level is accepted once it has differed from the current level for
      // DB_CYCLES samples in a row; any agreeing sample restarts the count.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          level_q <= '0;
          pulse_q <= '0;
          for (int i = 0; i < 6; i++) dbCnt_q[i] <= '0;
        end else begin
          for (int i = 0; i < 6; i++) begin
            pulse_q[i] <= 1'b0;
            if (sync2_q[i] == level_q[i]) begin
              dbCnt_q[i] <= '0;
            end else if (dbCnt_q[i] == DB_LAST) begin
              level_q[i] <= sync2_q[i];
              pulse_q[i] <= sync2_q[i];
              dbCnt_q[i] <= '0;
            end else begin
              dbCnt_q[i] <= dbCnt_q[i] + DB_W'(1);
            end
          end
        end
      end
    end
  endgenerate

  logic pRst, pErr, pPause, pCont, pUart, pStep;
  assign pRst   = pulse_q[0];
  assign pErr   = pulse_q[1];
  assign pPause = pulse_q[2];
  assign pCont  = pulse_q[3];
  assign pUart  = pulse_q[4];
  assign pStep  = pulse_q[5];

  logic [3:0]       mode_q, mode_d;
  logic [1:0]       cause_q, cause_d;
  logic             wdog_q, wdog_d;
  logic [ST_W-1:0]  stepCnt_q, stepCnt_d;
  logic [CNT_W-1:0] cycleCnt_q, cycleCnt_d;
  logic             running;
  logic             wdogHit;

  assign running = (mode_q == MODE_RUN) || (mode_q == MODE_STEP);
  assign wdogHit = (limit_i != '0) && ((cycleCnt_q + CNT_W'(1)) == limit_i);

  // Priority chain: earlier branches pre-empt everything below them.
  always_comb begin
    mode_d    = mode_q;
    cause_d   = cause_q;
    wdog_d    = wdog_q;
    stepCnt_d = stepCnt_q;
    if (pUart || exc_code_i == 4'd5) begin
      mode_d = MODE_UART;
    end else if (mode_q == MODE_UART) begin
      if (pCont || exc_code_i == 4'd6) mode_d = MODE_RUN;
    end else if (pRst) begin
      mode_d = MODE_RUN;
      wdog_d = 1'b0;
    end else if (pErr) begin
      mode_d  = MODE_ERROR;
      cause_d = CAUSE_BTN;
    end else if (exc_code_i == 4'd2) begin
      mode_d  = MODE_ERROR;
      cause_d = CAUSE_EXC;
    end else if (mode_q == MODE_ERROR) begin
      mode_d = MODE_ERROR;
    end else if (running && pPause) begin
      mode_d  = MODE_PAUSE;
      cause_d = CAUSE_BTN;
    end else if (running && exc_code_i == 4'd4) begin
      mode_d  = MODE_PAUSE;
      cause_d = CAUSE_EXC;
    end else if (mode_q == MODE_RUN && wdogHit) begin
      mode_d  = MODE_PAUSE;
      cause_d = CAUSE_WDOG;
      wdog_d  = 1'b1;
    end else if (mode_q == MODE_PAUSE) begin
      if (pCont || exc_code_i == 4'd1) begin
        mode_d = MODE_RUN;
      end else if (pStep) begin
        mode_d    = MODE_STEP;
        stepCnt_d = ST_W'(STEP_CYCLES);
      end
    end else if (mode_q == MODE_STEP) begin
      stepCnt_d = stepCnt_q - ST_W'(1);
      if (stepCnt_q == ST_W'(1)) begin
        mode_d  = MODE_PAUSE;
        cause_d = CAUSE_NONE;
      end
    end
    if (mode_d == MODE_RUN && mode_q != MODE_RUN) cause_d = CAUSE_NONE;
  end

  always_comb begin
    cycleCnt_d = cycleCnt_q;
    if (clr_cnt_i) begin
      cycleCnt_d = '0;
    end else if (running) begin
      cycleCnt_d = cycleCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q     <= MODE_PAUSE;
      cause_q    <= CAUSE_NONE;
      wdog_q     <= 1'b0;
      stepCnt_q  <= '0;
      cycleCnt_q <= '0;
    end else begin
      mode_q     <= mode_d;
      cause_q    <= cause_d;
      wdog_q     <= wdog_d;
      stepCnt_q  <= stepCnt_d;
      cycleCnt_q <= cycleCnt_d;
    end
  end

  assign mode_o       = mode_q;
  assign run_o        = running;
  assign cycle_cnt_o  = cycleCnt_q;
  assign halt_cause_o = cause_q;
  assign wdog_o       = wdog_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl (CNT_W=8, DB_CYCLES=4, STEP_CYCLES=3) with a
// queue of expected outputs compared after each stimulus step.
module tb_run_ctrl;

  localparam int CNT_W = 8;

  localparam logic [5:0] B_RST   = 6'b000001;
  localparam logic [5:0] B_ERR   = 6'b000010;
  localparam logic [5:0] B_PAUSE = 6'b000100;
  localparam logic [5:0] B_CONT  = 6'b001000;
  localparam logic [5:0] B_UART  = 6'b010000;
  localparam logic [5:0] B_STEP  = 6'b100000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [5:0]       btn = '0;
  logic [3:0]       exc = '0;
  logic             clrCnt = 1'b0;
  logic [CNT_W-1:0] limit = '0;
  logic [3:0]       mode;
  logic             run;
  logic [CNT_W-1:0] cycleCnt;
  logic [1:0]       cause;
  logic             wdog;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [3:0] mode;
    logic [1:0] cause;
    logic       wdog;
    int         cnt;
  } expect_t;

  expect_t sb[$];

  run_ctrl #(.CNT_W(CNT_W), .DB_CYCLES(4), .STEP_CYCLES(3)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .btn_rst_i(btn[0]),
    .btn_err_i(btn[1]),
    .btn_pause_i(btn[2]),
    .btn_continue_i(btn[3]),
    .btn_uart_i(btn[4]),
    .btn_step_i(btn[5]),
    .exc_code_i(exc),
    .clr_cnt_i(clrCnt),
    .limit_i(limit),
    .mode_o(mode),
    .run_o(run),
    .cycle_cnt_o(cycleCnt),
    .halt_cause_o(cause),
    .wdog_o(wdog)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are read there too.
  task automatic applyStimulus(input logic [5:0] b, input logic [3:0] e,
                               input logic c, input int n);
    btn    = b;
    exc    = e;
    clrCnt = c;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expectOut(input string tag, input logic [3:0] m,
                           input logic [1:0] c, input logic w, input int cnt);
    expect_t x;
    x.tag = tag; x.mode = m; x.cause = c; x.wdog = w; x.cnt = cnt;
    sb.push_back(x);
  endtask

  task automatic checkOutput();
    expect_t x;
    logic    expRun;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      expRun = (x.mode == 4'd5) || (x.mode == 4'd7);
      checks++;
      assert (mode === x.mode) else begin
        errors++;
        $error("[TB] FAIL %s.mode observed=%0d expected=%0d", x.tag, mode, x.mode);
      end
      checks++;
      assert (run === expRun) else begin
        errors++;
        $error("[TB] FAIL %s.run observed=%0d expected=%0d", x.tag, run, expRun);
      end
      checks++;
      assert (cause === x.cause) else begin
        errors++;
        $error("[TB] FAIL %s.cause observed=%0d expected=%0d", x.tag, cause, x.cause);
      end
      checks++;
      assert (wdog === x.wdog) else begin
        errors++;
        $error("[TB] FAIL %s.wdog observed=%0d expected=%0d", x.tag, wdog, x.wdog);
      end
      if (x.cnt >= 0) begin
        checks++;
        assert (cycleCnt === CNT_W'(x.cnt)) else begin
          errors++;
          $error("[TB] FAIL %s.cnt observed=%0d expected=%0d", x.tag, cycleCnt, x.cnt);
        end
      end
    end
  endtask

  initial begin
    applyStimulus('0, 4'd0, 1'b0, 2);
    rst = 1'b0;
    expectOut("reset", 4'd4, 2'd0, 1'b0, 0);
    checkOutput();

    applyStimulus(B_CONT, 4'd0, 1'b0, 6);
    expectOut("cont_pre", 4'd4, 2'd0, 1'b0, 0);
    checkOutput();
    applyStimulus(B_CONT, 4'd0, 1'b0, 1);
    expectOut("cont_run", 4'd5, 2'd0, 1'b0, 0);
    checkOutput();
    applyStimulus('0, 4'd0, 1'b0, 8);

    applyStimulus(B_PAUSE, 4'd0, 1'b0, 3);
    applyStimulus('0, 4'd0, 1'b0, 10);
    expectOut("glitch", 4'd5, 2'd0, 1'b0, -1);
    checkOutput();

    applyStimulus('0, 4'd0, 1'b1, 1);
    expectOut("clr1", 4'd5, 2'd0, 1'b0, 0);
    checkOutput();
    applyStimulus('0, 4'd0, 1'b0, 100);
    expectOut("cnt100", 4'd5, 2'd0, 1'b0, 100);
    checkOutput();
    applyStimulus('0, 4'd0, 1'b1, 1);
    expectOut("clr2", 4'd5, 2'd0, 1'b0, 0);
    checkOutput();
    applyStimulus('0, 4'd0, 1'b0, 300);
    expectOut("wrap", 4'd5, 2'd0, 1'b0, 44);
    checkOutput();

    applyStimulus(B_PAUSE, 4'd0, 1'b0, 7);
    expectOut("btn_pause", 4'd4, 2'd1, 1'b0, -1);
    checkOutput();
    applyStimulus('0, 4'd0, 1'b0, 8);

    applyStimulus('0, 4'd0, 1'b1, 1);
    applyStimulus(B_STEP, 4'd0, 1'b0, 7);
    expectOut("step_in", 4'd7, 2'd1, 1'b0, 0);
    checkOutput();
    applyStimulus(B_STEP, 4'd0, 1'b0, 2);
    expectOut("step_mid", 4'd7, 2'd1, 1'b0, 2);
    checkOutput();
    applyStimulus(B_STEP, 4'd0, 1'b0, 1);
    expectOut("step_done", 4'd4, 2'd0, 1'b0, 3);
    checkOutput();
    applyStimulus(B_STEP, 4'd0, 1'b0, 10);
    expectOut("step_hold", 4'd4, 2'd0, 1'b0, 3);
    checkOutput();
    applyStimulus('0, 4'd0, 1'b0, 8);

    applyStimulus('0, 4'd0, 1'b1, 1);
    limit = CNT_W'(50);
    applyStimulus('0, 4'd1, 1'b0, 1);
    expectOut("exc_resume", 4'd5, 2'd0, 1'b0, 0);
    checkOutput();
    applyStimulus('0, 4'd0, 1'b0, 49);
    expectOut("wd_before", 4'd5, 2'd0, 1'b0, 49);
    checkOutput();
    applyStimulus('0, 4'd0, 1'b0, 1);
    expectOut("wd_trip", 4'd4, 2'd3, 1'b1, 50);
    checkOutput();
    applyStimulus('0, 4'd0, 1'b0, 5);
    expectOut("wd_hold", 4'd4, 2'd3, 1'b1, 50);
    checkOutput();
    limit = '0;
    applyStimulus(B_RST, 4'd0, 1'b0, 7);
    expectOut("btn_rst", 4'd5, 2'd0, 1'b0, 50);
    checkOutput();
    applyStimulus('0, 4'd0, 1'b0, 8);

    applyStimulus('0, 4'd5, 1'b0, 1);
    expectOut("exc_uart", 4'd6, 2'd0, 1'b0, -1);
    checkOutput();
    applyStimulus(B_ERR | B_PAUSE, 4'd2, 1'b0, 7);
    expectOut("uart_ign", 4'd6, 2'd0, 1'b0, -1);
    checkOutput();
    applyStimulus('0, 4'd4, 1'b0, 1);
    applyStimulus('0, 4'd0, 1'b0, 8);
    expectOut("uart_ign2", 4'd6, 2'd0, 1'b0, -1);
    checkOutput();
    applyStimulus('0, 4'd6, 1'b0, 1);
    expectOut("uart_done", 4'd5, 2'd0, 1'b0, -1);
    checkOutput();
    applyStimulus('0, 4'd2, 1'b0, 1);
    expectOut("exc_err", 4'd2, 2'd2, 1'b0, -1);
    checkOutput();
    applyStimulus(B_CONT, 4'd0, 1'b0, 7);
    expectOut("err_hold", 4'd2, 2'd2, 1'b0, -1);
    checkOutput();
    applyStimulus('0, 4'd0, 1'b0, 8);

    applyStimulus(B_RST, 4'd0, 1'b0, 7);
    expectOut("err_exit", 4'd5, 2'd0, 1'b0, -1);
    checkOutput();
    applyStimulus('0, 4'd0, 1'b0, 8);
    applyStimulus(B_PAUSE, 4'd0, 1'b0, 6);
    expectOut("pe_pre", 4'd5, 2'd0, 1'b0, -1);
    checkOutput();
    applyStimulus(B_PAUSE, 4'd2, 1'b0, 1);
    expectOut("pause_vs_err", 4'd2, 2'd2, 1'b0, -1);
    checkOutput();
    applyStimulus('0, 4'd0, 1'b0, 8);

    applyStimulus(B_UART | B_RST, 4'd0, 1'b0, 7);
    expectOut("uart_vs_rst", 4'd6, 2'd2, 1'b0, -1);
    checkOutput();
    applyStimulus('0, 4'd0, 1'b0, 8);

    rst = 1'b1;
    applyStimulus('0, 4'd0, 1'b0, 1);
    rst = 1'b0;
    expectOut("reset2", 4'd4, 2'd0, 1'b0, 0);
    checkOutput();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
